// File: rtl/lcd_pkg.sv
// lcd_pkg: timing defaults, pixel format enum and RGB565 colour constants for the LCD controller
package lcd_pkg;
   typedef enum logic {FMT_GRAY8 = 1'b0, FMT_RGB565 = 1'b1} fmt_t;
   localparam int H_ACTIVE_DEF = 800;
   localparam int H_FRONT_DEF  = 40;
   localparam int H_SYNC_DEF   = 48;
   localparam int H_BACK_DEF   = 40;
   localparam int V_ACTIVE_DEF = 480;
   localparam int V_FRONT_DEF  = 13;
   localparam int V_SYNC_DEF   = 3;
   localparam int V_BACK_DEF   = 29;
   localparam int PCLK_DIV_DEF = 2;
   localparam logic [15:0] RGB_WHITE   = 16'hFFFF;
   localparam logic [15:0] RGB_YELLOW  = 16'hFFE0;
   localparam logic [15:0] RGB_CYAN    = 16'h07FF;
   localparam logic [15:0] RGB_GREEN   = 16'h07E0;
   localparam logic [15:0] RGB_MAGENTA = 16'hF81F;
   localparam logic [15:0] RGB_RED     = 16'hF800;
   localparam logic [15:0] RGB_BLUE    = 16'h001F;
   localparam logic [15:0] RGB_BLACK   = 16'h0000;
   localparam logic [15:0] BORDER_DEF  = RGB_BLACK;
   // element 0 is the leftmost bar
   localparam logic [7:0][15:0] BAR_RGB = {RGB_BLACK, RGB_BLUE, RGB_RED, RGB_MAGENTA,
                                           RGB_GREEN, RGB_CYAN, RGB_YELLOW, RGB_WHITE};
   function automatic logic [15:0] gray_to_rgb565(input logic [7:0] d);
      return {d[7:3], d[7:2], d[7:3]};
   endfunction
endpackage

// File: rtl/lcd_timing_gen.sv
// lcd_timing_gen: pixel enable, lcd_clk, h/v raster counters, raw sync/active flags and frame markers
module lcd_timing_gen
   import lcd_pkg::*;
#(
   parameter int H_ACTIVE = H_ACTIVE_DEF,
   parameter int H_FRONT  = H_FRONT_DEF,
   parameter int H_SYNC   = H_SYNC_DEF,
   parameter int H_BACK   = H_BACK_DEF,
   parameter int V_ACTIVE = V_ACTIVE_DEF,
   parameter int V_FRONT  = V_FRONT_DEF,
   parameter int V_SYNC   = V_SYNC_DEF,
   parameter int V_BACK   = V_BACK_DEF,
   parameter int PCLK_DIV = PCLK_DIV_DEF
) (
   input  logic        clk,
   input  logic        rst,
   output logic        pix_ce,
   output logic        run,
   output logic        lcd_clk,
   output logic [15:0] h_count,
   output logic [15:0] v_count,
   output logic        hs_raw,
   output logic        vs_raw,
   output logic        act_raw,
   output logic        frame_end,
   output logic        frame_start
);
   localparam logic [15:0] H_LAST = 16'(H_ACTIVE + H_FRONT + H_SYNC + H_BACK - 1);
   localparam logic [15:0] V_LAST = 16'(V_ACTIVE + V_FRONT + V_SYNC + V_BACK - 1);
   localparam logic [15:0] HS_BEG = 16'(H_ACTIVE + H_FRONT);
   localparam logic [15:0] HS_END = 16'(H_ACTIVE + H_FRONT + H_SYNC);
   localparam logic [15:0] VS_BEG = 16'(V_ACTIVE + V_FRONT);
   localparam logic [15:0] VS_END = 16'(V_ACTIVE + V_FRONT + V_SYNC);
   localparam logic [15:0] HA     = 16'(H_ACTIVE);
   localparam logic [15:0] VA     = 16'(V_ACTIVE);
   localparam logic [7:0]  DIV_LAST = 8'(PCLK_DIV - 1);
   localparam logic [7:0]  CLK_HI   = 8'(PCLK_DIV / 2);
   logic [7:0] div, div_nxt;
   logic       h_last, v_last;
   assign pix_ce    = div == DIV_LAST;
   assign div_nxt   = (!run || pix_ce) ? 8'd0 : div + 8'd1;
   assign h_last    = h_count == H_LAST;
   assign v_last    = v_count == V_LAST;
   assign frame_end = pix_ce && h_last && v_last;
   assign hs_raw    = h_count >= HS_BEG && h_count < HS_END;
   assign vs_raw    = v_count >= VS_BEG && v_count < VS_END;
   assign act_raw   = h_count < HA && v_count < VA;
   // divider and raster counters; the first clk after reset is spent announcing the frame at (0,0)
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         run         <= 1'b0;
         div         <= 8'd0;
         lcd_clk     <= 1'b0;
         frame_start <= 1'b0;
         h_count     <= 16'd0;
         v_count     <= 16'd0;
      end else begin
         run         <= 1'b1;
         div         <= div_nxt;
         lcd_clk     <= div_nxt >= CLK_HI;
         frame_start <= !run || frame_end;
         if (pix_ce) h_count <= h_last ? 16'd0 : h_count + 16'd1;
         if (pix_ce && h_last) v_count <= v_last ? 16'd0 : v_count + 16'd1;
      end
endmodule

// File: rtl/lcd_scaled_display_ctrl.sv
// lcd_scaled_display_ctrl: scaled, letterboxed framebuffer-to-RGB-panel driver; LCD_TEST_PATTERN_EN adds colour bars
module lcd_scaled_display_ctrl
   import lcd_pkg::*;
#(
   parameter int          H_ACTIVE   = H_ACTIVE_DEF,
   parameter int          H_FRONT    = H_FRONT_DEF,
   parameter int          H_SYNC     = H_SYNC_DEF,
   parameter int          H_BACK     = H_BACK_DEF,
   parameter int          V_ACTIVE   = V_ACTIVE_DEF,
   parameter int          V_FRONT    = V_FRONT_DEF,
   parameter int          V_SYNC     = V_SYNC_DEF,
   parameter int          V_BACK     = V_BACK_DEF,
   parameter int          PCLK_DIV   = PCLK_DIV_DEF,
   parameter int          SRC_W      = 200,
   parameter int          SRC_H      = 160,
   parameter int          H_SCALE    = 4,
   parameter int          V_SCALE    = 3,
   parameter int          ADDR_W     = 15,
   parameter logic        SYNC_POL   = 1'b1,
   parameter logic [15:0] BORDER_RGB = BORDER_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              fmt_sel,
`ifdef LCD_TEST_PATTERN_EN
   input  logic              tp_en,
`endif
   output logic              bram_en,
   output logic [ADDR_W-1:0] bram_addr,
   input  logic [15:0]       bram_data,
   output logic              lcd_clk,
   output logic              lcd_hsync,
   output logic              lcd_vsync,
   output logic              lcd_de,
   output logic [4:0]        lcd_r,
   output logic [5:0]        lcd_g,
   output logic [4:0]        lcd_b,
   output logic              frame_start
);
   localparam logic [15:0]       IMG_W      = 16'(SRC_W * H_SCALE);
   localparam logic [15:0]       IMG_H      = 16'(SRC_H * V_SCALE);
   localparam logic [15:0]       IMG_W_LAST = 16'(SRC_W * H_SCALE - 1);
   localparam logic [15:0]       HREP_LAST  = 16'(H_SCALE - 1);
   localparam logic [15:0]       VREP_LAST  = 16'(V_SCALE - 1);
   localparam logic [ADDR_W-1:0] SRC_STEP   = ADDR_W'(SRC_W);
   logic              pix_ce, run, hs_raw, vs_raw, act_raw, frame_end;
   logic              img, line_end, base_step, tp_sel, tp_on;
   logic [15:0]       h_count, v_count, hrep, vrep, bar_col, pix_rgb, rgb_q;
   logic [ADDR_W-1:0] line_base;
   fmt_t              fmt_q;
   lcd_timing_gen #(
      .H_ACTIVE(H_ACTIVE), .H_FRONT(H_FRONT), .H_SYNC(H_SYNC), .H_BACK(H_BACK),
      .V_ACTIVE(V_ACTIVE), .V_FRONT(V_FRONT), .V_SYNC(V_SYNC), .V_BACK(V_BACK),
      .PCLK_DIV(PCLK_DIV)
   ) u_timing (
      .clk(clk), .rst(rst), .pix_ce(pix_ce), .run(run), .lcd_clk(lcd_clk),
      .h_count(h_count), .v_count(v_count), .hs_raw(hs_raw), .vs_raw(vs_raw),
      .act_raw(act_raw), .frame_end(frame_end), .frame_start(frame_start)
   );
`ifdef LCD_TEST_PATTERN_EN
   localparam logic [15:0] HA_LAST  = 16'(H_ACTIVE - 1);
   localparam logic [15:0] BAR_LAST = 16'(H_ACTIVE / 8 - 1);
   logic [15:0] bar_cnt;
   logic [2:0]  bar_idx;
   logic        tp_q;
   assign tp_sel  = frame_start ? tp_en : tp_q;
   assign tp_on   = tp_q;
   assign bar_col = BAR_RGB[bar_idx];
   // test-pattern latch and bar position; the last bar keeps counting so it absorbs any remainder
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         tp_q    <= 1'b0;
         bar_cnt <= 16'd0;
         bar_idx <= 3'd0;
      end else begin
         if (frame_start) tp_q <= tp_en;
         if (pix_ce) begin
            if (h_count >= HA_LAST) begin
               bar_cnt <= 16'd0;
               bar_idx <= 3'd0;
            end else if (bar_cnt == BAR_LAST && bar_idx != 3'd7) begin
               bar_cnt <= 16'd0;
               bar_idx <= bar_idx + 3'd1;
            end else bar_cnt <= bar_cnt + 16'd1;
         end
      end
`else
   assign tp_sel  = 1'b0;
   assign tp_on   = 1'b0;
   assign bar_col = 16'h0000;
`endif
   assign img       = h_count < IMG_W && v_count < IMG_H;
   assign bram_en   = run && img && !tp_sel;
   assign line_end  = h_count == IMG_W_LAST;
   assign base_step = vrep == VREP_LAST;
   assign pix_rgb   = !act_raw ? 16'h0000 : tp_on ? bar_col : !img ? BORDER_RGB :
                      fmt_q == FMT_RGB565 ? bram_data : gray_to_rgb565(bram_data[7:0]);
   assign {lcd_r, lcd_g, lcd_b} = rgb_q;
   // format is latched once per frame so mid-frame changes wait for the next frame
   always_ff @(posedge clk or posedge rst)
      if (rst) fmt_q <= FMT_GRAY8;
      else if (frame_start) fmt_q <= fmt_t'(fmt_sel);
   // scaler address walk: hrep replicates pixels, vrep replays a source line before stepping line_base
   always_ff @(posedge clk or posedge rst)
      if (rst || frame_end) begin
         hrep      <= 16'd0;
         vrep      <= 16'd0;
         line_base <= '0;
         bram_addr <= '0;
      end else if (pix_ce && img && !tp_on) begin
         if (line_end) begin
            hrep      <= 16'd0;
            vrep      <= base_step ? 16'd0 : vrep + 16'd1;
            line_base <= base_step ? line_base + SRC_STEP : line_base;
            bram_addr <= base_step ? line_base + SRC_STEP : line_base;
         end else begin
            hrep      <= hrep == HREP_LAST ? 16'd0 : hrep + 16'd1;
            bram_addr <= hrep == HREP_LAST ? bram_addr + ADDR_W'(1) : bram_addr;
         end
      end
   // one-pixel output stage: data and the flags that belong to it land on the pins together
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         lcd_hsync <= ~SYNC_POL;
         lcd_vsync <= ~SYNC_POL;
         lcd_de    <= 1'b0;
         rgb_q     <= 16'h0000;
      end else if (pix_ce) begin
         lcd_hsync <= hs_raw ? SYNC_POL : ~SYNC_POL;
         lcd_vsync <= vs_raw ? SYNC_POL : ~SYNC_POL;
         lcd_de    <= act_raw;
         rgb_q     <= pix_rgb;
      end
endmodule

// File: tb/tb_lcd_scaled_display_ctrl.sv
// tb_lcd_scaled_display_ctrl: scoreboard bench on a 12x7 raster (8x4 active) with a 3x2 source scaled 2x2
`timescale 1ns/1ps
module tb_lcd_scaled_display_ctrl;
   localparam int HT = 12, VT = 7, NPIX = HT * VT;
   typedef struct packed {
      logic [18:0] out;
      logic        en;
      logic        chk_addr;
      logic [3:0]  addr;
   } exp_t;
   logic clk = 1'b0, rst = 1'b1, fmt_sel = 1'b0;
`ifdef LCD_TEST_PATTERN_EN
   logic tp_en = 1'b0;
`endif
   logic        bram_en, lcd_clk, lcd_hsync, lcd_vsync, lcd_de, frame_start;
   logic [3:0]  bram_addr;
   logic [15:0] bram_data;
   logic [4:0]  lcd_r, lcd_b;
   logic [5:0]  lcd_g;
   logic [15:0] mem [16];
   logic [15:0] bars [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0, 16'hF81F, 16'hF800, 16'h001F, 16'h0000};
   exp_t q[$];
   exp_t me;
   int   chk_cnt = 0, pass_cnt = 0, mon_k = 0, cnt;

   always #5 clk = ~clk;
   assign bram_data = mem[bram_addr];

   lcd_scaled_display_ctrl #(
      .H_ACTIVE(8), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
      .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
      .PCLK_DIV(2), .SRC_W(3), .SRC_H(2), .H_SCALE(2), .V_SCALE(2),
      .ADDR_W(4), .SYNC_POL(1'b1), .BORDER_RGB(16'h07E0)
   ) dut (
      .clk(clk), .rst(rst), .fmt_sel(fmt_sel),
`ifdef LCD_TEST_PATTERN_EN
      .tp_en(tp_en),
`endif
      .bram_en(bram_en), .bram_addr(bram_addr), .bram_data(bram_data),
      .lcd_clk(lcd_clk), .lcd_hsync(lcd_hsync), .lcd_vsync(lcd_vsync), .lcd_de(lcd_de),
      .lcd_r(lcd_r), .lcd_g(lcd_g), .lcd_b(lcd_b), .frame_start(frame_start)
   );

   // expected {de,hs,vs,rgb} for raster pixel p in a frame with format f and test pattern t
   function automatic logic [18:0] pix_out(input int p, input logic f, input logic t);
      int h = p % HT, v = p / HT;
      logic de = h < 8 && v < 4;
      logic hs = h == 9 || h == 10;
      logic vs = v == 5;
      logic [15:0] d, rgb;
      d = mem[(v / 2) * 3 + h / 2];
      rgb = !de ? 16'h0000 : t ? bars[h] : h >= 6 ? 16'h07E0 : f ? d : {d[7:3], d[7:2], d[7:3]};
      return {de, hs, vs, rgb};
   endfunction

   // stream entry k: pins show pixel k-1 (reset values for k=0), bram shows pixel k
   task automatic push_frames(input int nf, input logic [3:0] fm, input logic t);
      for (int k = 0; k <= nf * NPIX; k++) begin
         exp_t e;
         int p = k % NPIX;
         int hq = p % HT, vq = p / HT;
         e.out      = k == 0 ? 19'd0 : pix_out((k - 1) % NPIX, fm[(k - 1) / NPIX], t);
         e.en       = !t && hq < 6 && vq < 4;
         e.chk_addr = e.en || t;
         e.addr     = t ? 4'd0 : 4'((vq / 2) * 3 + hq / 2);
         q.push_back(e);
      end
   endtask

   task automatic check_reset(input string nm);
      logic [25:0] act = {lcd_clk, lcd_hsync, lcd_vsync, lcd_de, lcd_r, lcd_g, lcd_b, bram_en, bram_addr, frame_start};
      chk_cnt++;
      if (act === 26'd0) pass_cnt++;
      else $display("FAIL %s: outputs %h, required 0", nm, act);
   endtask

   task automatic check_bit(input string nm, input logic a, input logic x);
      chk_cnt++;
      if (a === x) pass_cnt++;
      else $display("FAIL %s: got %b, required %b", nm, a, x);
   endtask

   task automatic drain();
      int n = 0;
      while (q.size() != 0 && n < 1000) begin
         @(negedge clk);
         n++;
      end
      chk_cnt++;
      if (q.size() == 0) pass_cnt++;
      else $display("FAIL drain: %0d entries left, required 0", q.size());
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      while (lcd_clk) @(negedge clk);
      rst = 1'b1;
      q.delete();
      #1;
      check_reset("mid_reset");
      @(negedge clk);
      rst = 1'b0;
   endtask

   // monitor: one sample per pixel period, mid-way through the lcd_clk high phase
   always @(posedge lcd_clk) begin
      @(negedge clk);
      if (q.size() > 0) begin
         me = q.pop_front();
         chk_cnt++;
         if ({lcd_de, lcd_hsync, lcd_vsync, lcd_r, lcd_g, lcd_b} === me.out) pass_cnt++;
         else $display("FAIL pix[%0d]: de/hs/vs/rgb %h, required %h", mon_k,
                       {lcd_de, lcd_hsync, lcd_vsync, lcd_r, lcd_g, lcd_b}, me.out);
         chk_cnt++;
         if (bram_en === me.en) pass_cnt++;
         else $display("FAIL en[%0d]: bram_en %b, required %b", mon_k, bram_en, me.en);
         if (me.chk_addr) begin
            chk_cnt++;
            if (bram_addr === me.addr) pass_cnt++;
            else $display("FAIL addr[%0d]: bram_addr %0d, required %0d", mon_k, bram_addr, me.addr);
         end
         mon_k++;
      end
   end

   initial begin
      for (int i = 0; i < 16; i++) mem[i] = 16'h0000;
      mem[0] = 16'hF81F;
      mem[1] = 16'h1234;
      mem[2] = 16'h00FF;
      mem[3] = 16'hABCD;
      mem[4] = 16'h0080;
      mem[5] = 16'h5A5A;
      repeat (3) @(negedge clk);
      check_reset("init_reset");
      push_frames(2, 4'b0010, 1'b0);
      rst = 1'b0;
      @(posedge clk);
      #1;
      check_bit("first_frame_start", frame_start, 1'b1);
      cnt = 0;
      while (cnt < 300) begin
         @(posedge clk);
         #1;
         cnt++;
         if (cnt == 80) fmt_sel = 1'b1;
         if (frame_start) break;
      end
      chk_cnt++;
      if (cnt == 168) pass_cnt++;
      else $display("FAIL frame_period: %0d clk, required 168", cnt);
      repeat (30) @(posedge clk);
      fmt_sel = 1'b0;
      pulse_reset();
      push_frames(1, 4'b0000, 1'b0);
      @(posedge clk);
      #1;
      check_bit("post_reset_frame_start", frame_start, 1'b1);
      @(posedge clk);
      #1;
      check_bit("frame_start_one_clk", frame_start, 1'b0);
      drain();
`ifdef LCD_TEST_PATTERN_EN
      tp_en = 1'b1;
      pulse_reset();
      push_frames(1, 4'b0000, 1'b1);
      drain();
`endif
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end
endmodule

// File: doc/lcd_scaled_display_ctrl.md
Name: lcd_scaled_display_ctrl

Overview:
Parametrised successor to the fixed 800x480 grayscale LCD driver. It generates programmable RGB parallel-panel timing from a single system clock and reads a small framebuffer BRAM. Pixels are upscaled by integer replication (counters only, no multipliers) and letterboxed with a border colour. The BRAM holds either 8-bit grayscale or RGB565 pixels; it sits between the frame-buffer BRAM and the panel pins.

Parameters:
H_ACTIVE, 800, visible pixels per line
H_FRONT / H_SYNC / H_BACK, 40 / 48 / 40, horizontal porch and sync widths in pixels
V_ACTIVE, 480, visible lines
V_FRONT / V_SYNC / V_BACK, 13 / 3 / 29, vertical porch and sync widths in lines
PCLK_DIV, 2, clk cycles per pixel; must be >= 2
SRC_W / SRC_H, 200 / 160, framebuffer size in source pixels
H_SCALE / V_SCALE, 4 / 3, integer replication factors; SRC_W*H_SCALE <= H_ACTIVE and SRC_H*V_SCALE <= V_ACTIVE
ADDR_W, 15, BRAM address width; 2**ADDR_W >= SRC_W*SRC_H
SYNC_POL, 1, asserted level of hsync and vsync
BORDER_RGB, 16'h0000, RGB565 colour outside the scaled image

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
fmt_sel  in  1  0 = 8-bit gray in data[7:0], 1 = RGB565; sampled at frame start
bram_en  out  1  read enable
bram_addr  out  ADDR_W  read address
bram_data  in  16  read data; latency must be <= PCLK_DIV-1 clk cycles
lcd_clk  out  1  pixel clock
lcd_hsync  out  1  horizontal sync
lcd_vsync  out  1  vertical sync
lcd_de  out  1  data enable
lcd_r  out  5  red
lcd_g  out  6  green
lcd_b  out  5  blue
frame_start  out  1  one-clk pulse at pixel (0,0)

Behaviour:
- Reset values: counters 0, lcd_clk 0, lcd_de 0, RGB 0, bram_en 0, bram_addr 0, frame_start 0. Syncs are driven to ~SYNC_POL.
- A reset mid-frame aborts the frame. Output restarts at h=v=0 after reset deasserts.
- Pixel enable pix_ce pulses every PCLK_DIV clk cycles.
- lcd_clk is low for the first floor(PCLK_DIV/2) cycles of each pixel period and high for the rest. Outputs change on the falling edge and the panel samples on the rising edge.
- h_count advances on pix_ce and wraps at H_TOTAL-1. v_count advances when h wraps and itself wraps at V_TOTAL-1.
- Sync is asserted for h in [H_ACTIVE+H_FRONT, +H_SYNC). vsync uses the same rule with the V parameters.
- Image region: h < SRC_W*H_SCALE and v < SRC_H*V_SCALE. bram_en is 1 only inside it.
- Address generation (no multiply):
  - hrep counts 0..H_SCALE-1 and increments bram_addr on wrap.
  - At the end of each image line, vrep increments. If vrep was V_SCALE-1, line_base += SRC_W; otherwise bram_addr reloads line_base to repeat the source line.
  - line_base, bram_addr, hrep and vrep clear at frame start.
- Pipeline: bram_addr is issued in pixel period N; data is registered at pix_ce ending period N.
  - lcd_de, the syncs and the region flag are delayed one pixel period to match.
  - Total latency from counter to pins is exactly one pixel period.
- Output colour:
  - Inside the image with fmt=0: r=d[7:3], g=d[7:2], b=d[7:3].
  - Inside the image with fmt=1: r=d[15:11], g=d[10:5], b=d[4:0].
  - Active area but outside the image: BORDER_RGB.
  - lcd_de=0: RGB=0.
- fmt_sel is latched only at h=v=0; changes mid-frame take effect on the next frame.
- frame_start pulses on the clk where the counters reach (0,0).

Optional Feature:
LCD_TEST_PATTERN_EN:
- Defined: adds input tp_en (1 bit), sampled at frame start.
- When the latched tp_en=1: bram_en=0, bram_addr held at 0, and the active area shows 8 vertical colour bars. Bar order: white, yellow, cyan, green, magenta, red, blue, black.
- Each bar is H_ACTIVE/8 wide. The bar index comes from a counter reset per line, not a divide. The last bar absorbs any remainder.
- Not defined: port absent; always framebuffer.

Decomposition:
- Package lcd_pkg: timing defaults, fmt enum (FMT_GRAY8, FMT_RGB565), RGB565 colour constants for bars and border.
- Sub-module lcd_timing_gen: pix_ce, lcd_clk, h/v counters, raw sync/active flags, frame_start.
- The top level holds the scaler address generator, the pipeline and the colour mux.

Test Plan:
- Small config (H 8/1/2/1, V 4/1/1/1, PCLK_DIV 2, SRC 4x2, scale 2x2), reset release → per frame: hsync asserted for 2 pixels, vsync for 1 line; lcd_de high for 8x4 pixels; frame period 12*7*2 = 168 clk.
- Same config, address trace across one frame → per line: 0,0,1,1,2,2,3,3 on lines 0-1, then 4,4,5,5,6,6,7,7 on lines 2-3.
- BRAM model returning the address as data, fmt=1, bram_data=16'hF81F → lcd_r=31, lcd_g=0, lcd_b=31, one pixel period after that address.
- SRC 3x2, scale 2x2, H_ACTIVE 8, BORDER_RGB=16'h07E0 → output pixels 6-7 of each line show g=63, r=b=0, with bram_en=0.
- Toggle fmt_sel mid-frame, and assert rst for 1 clk mid-line → format changes only after the next frame_start; after reset, all outputs return to their reset values within the same clk and the first frame_start comes 1 clk after rst falls.
- With LCD_TEST_PATTERN_EN and tp_en=1, H_ACTIVE=16 → bars each 2 pixels wide; pixel 0 = (31,63,31), pixel 14 = (0,0,0); bram_en stays 0.
